// File: rtl/hazard_lock_unit_if.sv
// rtl/hazard_lock_unit_if.sv - OF-stage lock/hazard signal bundle between pipeline and hazard_lock_unit
interface hazard_lock_unit_if;
    logic [31:0] instruction_of;
    logic        is_branch_taken;
    logic        isbranch_lock_for_IF_latch;
    logic        isbranch_lock_for_OF_latch;
    logic        hazard_from_data_lock;
    logic [15:0] stall_count;

    modport master (
        output instruction_of,
        output is_branch_taken,
        input  isbranch_lock_for_IF_latch,
        input  isbranch_lock_for_OF_latch,
        input  hazard_from_data_lock,
        input  stall_count
    );

    modport slave (
        input  instruction_of,
        input  is_branch_taken,
        output isbranch_lock_for_IF_latch,
        output isbranch_lock_for_OF_latch,
        output hazard_from_data_lock,
        output stall_count
    );
endinterface

// File: rtl/hazard_lock_unit.sv
// rtl/hazard_lock_unit.sv - SimpleRISC countdown-scoreboard hazard/branch lock generator (option: HAZARD_FORWARDING_EN)
module hazard_lock_unit #(
    parameter int SB_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_lock_unit_if.slave hl
);

    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_NOT  = 5'd8;
    localparam logic [4:0] OP_MOV  = 5'd9;
    localparam logic [4:0] OP_ASR  = 5'd12;
    localparam logic [4:0] OP_NOP  = 5'd13;
    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_ST   = 5'd15;
    localparam logic [4:0] OP_BEQ  = 5'd16;
    localparam logic [4:0] OP_BGT  = 5'd17;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;
    localparam int         FLAGS   = 16;
    localparam logic [1:0] LOAD_FULL = 2'(SB_DEPTH);

    logic [4:0]  opcode;
    logic        imm_bit;
    logic [3:0]  rd, rs1, rs2;
    logic [16:0] src_mask;
    logic [16:0] busy;
    logic        dst_valid;
    logic [4:0]  dst_idx;
    logic [1:0]  dst_val;
    logic        raw;
    logic        issue;
    logic [1:0]  cnt [17];

    assign opcode  = hl.instruction_of[31:27];
    assign imm_bit = hl.instruction_of[26];
    assign rd      = hl.instruction_of[25:22];
    assign rs1     = hl.instruction_of[21:18];
    assign rs2     = hl.instruction_of[17:14];

    always_comb begin
        src_mask = '0;
        if ((opcode <= OP_ASR && opcode != OP_NOT && opcode != OP_MOV) ||
            opcode == OP_LD || opcode == OP_ST)
            src_mask[{1'b0, rs1}] = 1'b1;
        if (opcode <= OP_ASR && !imm_bit)
            src_mask[{1'b0, rs2}] = 1'b1;
        if (opcode == OP_ST)
            src_mask[{1'b0, rd}] = 1'b1;
        if (opcode == OP_RET)
            src_mask[15] = 1'b1;
        if (opcode == OP_BEQ || opcode == OP_BGT)
            src_mask[FLAGS] = 1'b1;
    end

    always_comb begin
        dst_valid = 1'b0;
        dst_idx   = {1'b0, rd};
        if ((opcode <= OP_ASR && opcode != OP_CMP) || opcode == OP_LD) begin
            dst_valid = 1'b1;
        end else if (opcode == OP_CMP) begin
            dst_valid = 1'b1;
            dst_idx   = 5'(FLAGS);
        end else if (opcode == OP_CALL) begin
            dst_valid = 1'b1;
            dst_idx   = 5'd15;
        end
`ifdef HAZARD_FORWARDING_EN
        // Only load-use survives forwarding; every other result is bypassed.
        dst_val = (opcode == OP_LD) ? 2'd1 : 2'd0;
`else
        dst_val = LOAD_FULL;
`endif
    end

    always_comb begin
        for (int i = 0; i < 17; i++)
            busy[i] = (cnt[i] != 2'd0);
    end

    assign raw   = |(src_mask & busy);
    assign issue = !raw && !hl.is_branch_taken && (opcode != OP_NOP);

    // Branch lock wins over hazard so a squashed instruction never stalls.
    assign hl.hazard_from_data_lock      = raw && !hl.is_branch_taken;
    assign hl.isbranch_lock_for_IF_latch = hl.is_branch_taken;
    assign hl.isbranch_lock_for_OF_latch = hl.is_branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 17; i++)
                cnt[i] <= 2'd0;
            hl.stall_count <= 16'd0;
        end else begin
            for (int i = 0; i < 17; i++) begin
                if (issue && dst_valid && dst_idx == 5'(i))
                    cnt[i] <= dst_val;
                else if (cnt[i] != 2'd0)
                    cnt[i] <= cnt[i] - 2'd1;
            end
            if (hl.hazard_from_data_lock && hl.stall_count != 16'hFFFF)
                hl.stall_count <= hl.stall_count + 16'd1;
        end
    end

endmodule

// File: doc/hazard_lock_unit.md
# hazard_lock_unit

Pipeline control block that generates the lock signals consumed by the IF/OF and OF/EX latches of the 5-stage SimpleRISC pipeline (IF, OF, EX, MA, RW). It tracks in-flight register and flag writes in a per-register countdown scoreboard and raises a data-hazard stall when the instruction in OF reads a pending destination. It raises branch locks that squash wrong-path instructions when EX resolves a taken branch. The block sits beside the OF stage: it reads the IF/OF latch output and the EX branch outcome, and drives the latch control inputs.

## Interface
- `SB_DEPTH`, 3: countdown loaded for a non-forwarded write (covers EX, MA, RW).
- `clk`  in  1: pipeline clock; all state updates on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low; clears all state.
- `instruction_of`  in  32: instruction in OF (IF/OF latch `instruction_out`).
- `is_branch_taken`  in  1: EX holds a taken branch/call/ret this cycle.
- `isbranch_lock_for_IF_latch`  out  1: IF/OF latch loads NOP (0x68000000).
- `isbranch_lock_for_OF_latch`  out  1: OF/EX latch loads NOP.
- `hazard_from_data_lock`  out  1: IF/OF latch and PC hold.
- `stall_count`  out  16: saturating count of data-stall cycles.

## Operation
- Decode fields: opcode [31:27], I [26], rd [25:22], rs1 [21:18], rs2 [17:14].
- Writers of rd: add, sub, mul, div, mod, and, or, not, mov, lsl, lsr, asr, ld (opcodes 0–4, 6–12, 14).
- call (19) writes r15. cmp (5) writes flags, which use scoreboard entry 16.
- Readers:
  - rs1: all ALU ops except not/mov, plus ld and st.
  - rs2: when I=0 for ALU ops, cmp, not and mov.
  - rd: st.
  - r15: ret.
  - flags: beq/bgt.
  - nop, b and call have no sources.
- Scoreboard: 17 entries of 2-bit counters. Every cycle, each nonzero counter decrements by 1.
- `hazard` = any valid source counter != 0, qualified by not `is_branch_taken`.
- Issue happens when the OF instruction is neither hazarded nor branch-locked. On issue, the destination counter loads the issue value; this load overrides the decrement for that entry.
- `isbranch_lock_for_IF_latch` = `isbranch_lock_for_OF_latch` = `is_branch_taken` (combinational). The OF instruction is not issued.
- `hazard_from_data_lock` = `hazard`. OF/EX bubble insertion uses lock OR hazard; the downstream latch decodes this.
- Branch lock has priority over hazard, so a squashed instruction never stalls.
- `stall_count` increments on each cycle with `hazard_from_data_lock`=1 and saturates at 0xFFFF.
- r0 is not special: it is tracked like any other register.

## Timing
- Reset (rst_n low, any time): all counters 0 and `stall_count` 0. All outputs are 0 while `is_branch_taken`=0. Reset mid-stall releases the stall immediately.
- Lock and hazard outputs are combinational from the inputs and current counters (same-cycle). The latches sample them at the next rising edge.
- Without forwarding, a RAW-dependent instruction directly behind its producer stalls exactly `SB_DEPTH` cycles: counter values 3, 2, 1 stall, 0 releases.
- One cycle of separation gives 2 stalls; separation of `SB_DEPTH` or more cycles gives 0.
- Simultaneous issue of a new write to an entry already counting: load wins (reload to the issue value).
- `is_branch_taken` during a stall: stall drops that cycle, both locks assert, and counters keep decrementing.

## Configuration
- `HAZARD_FORWARDING_EN` defined:
  - Only ld loads its destination counter, with value 1 (load-use, 1 stall).
  - All other writers, including cmp flags and call r15, load 0 and never stall.
- Undefined: every writer loads `SB_DEPTH`.

## Test plan
- Reset: rst_n=0 with `instruction_of` = add r1,r2,r3 → all outputs 0, `stall_count`=0.
- No forwarding, add r1,r2,r3 then add r4,r1,r5 back-to-back → `hazard_from_data_lock` high exactly 3 cycles, then the second add issues; `stall_count`=3.
- cmp r1,r2 then beq → 3-cycle stall on the flags entry. An intervening nop reduces this to 2 stalls.
- Stall in progress (counter=2) plus `is_branch_taken`=1 → that cycle hazard=0 and both locks=1. The next cycle the counter is 1.
- `HAZARD_FORWARDING_EN`, ld r1,[r2] then add r3,r1,r4 → 1 stall cycle. The same sequence with mov r1 → 0 stalls.
- st r5,[r6] after mul r5 → stall via the rd-as-source path. rst_n pulsed low mid-stall → hazard drops asynchronously.
